iddmm_final_sub: RTL and testbench
==================================

// Module: iddmm_final_sub
// PURPOSE
// - Final conditional-subtraction stage of the IDDMM Montgomery multiplier, on the read side of the accumulator.
// - Consumes the (K*N+1)-bit product T as N K-bit words, LSW first, plus one top bit, alongside modulus M words.
// - Computes T-M with a word-serial borrow chain and buffers both T and T-M.
// - Emits R = (T >= M) ? T-M : T as N words under a valid/ready handshake.
// PARAMETERS
// - K       256          word width in bits
// - N       16           words per operand
// - ADDR_W  $clog2(N)    word-index width
// PORTS
// - clk        in   1       clock, all flops on rising edge
// - rst_n      in   1       asynchronous reset, active low
// - start      in   1       1-cycle pulse, begins an operation; honoured only when busy=0
// - t_msb      in   1       top bit of T (bit K*N), sampled on accepted start
// - in_valid   in   1       t_word/m_word valid this cycle
// - t_word     in   K       T word, index = internal counter
// - m_word     in   K       M word, same index as t_word
// - res_valid  out  1       res_word valid
// - res_ready  in   1       sink accepts res_word
// - res_word   out  K       result word, LSW first
// - res_idx    out  ADDR_W  index of res_word
// - busy       out  1       high from accepted start until done
// - done       out  1       1-cycle pulse after the last result word is accepted
// BEHAVIOUR
// - Reset: FSM=IDLE, cnt=0, borrow=0, sel=0; outputs res_valid=0, res_word=0, res_idx=0, busy=0, done=0.
//   Buffers need no reset.
// - FSM IDLE -> SUB -> OUT -> IDLE.
// - IDLE:
//   - start=1: latch t_msb, clear borrow and cnt, set busy, go SUB.
//   - in_valid ignored.
// - SUB:
//   - Each cycle with in_valid=1:
//     - d = {1'b0,t_word} - {1'b0,m_word} - borrow, (K+1) bits.
//     - buf_t[cnt] <= t_word; buf_d[cnt] <= d[K-1:0]; borrow <= d[K]; cnt++.
//   - in_valid=0 stalls with no state change.
//   - On accepting word N-1:
//     - sel <= t_msb | ~d[K], i.e. T >= M.
//     - cnt <= 0; go OUT.
// - OUT:
//   - res_valid=1 starting the cycle after the last input word is accepted.
//   - res_word = sel ? buf_d[cnt] : buf_t[cnt]; res_idx = cnt.
//   - res_word/res_idx are held stable while res_valid && !res_ready.
//   - On res_valid && res_ready: cnt++.
//   - On acceptance of word N-1: res_valid<=0, busy<=0, done<=1 for one cycle, go IDLE.
// - start while busy=1 is ignored; in_valid outside SUB is ignored.
// - T == M: no borrow, so sel=1 and R = 0.
// - t_msb=1: sel=1 regardless of borrow. The result T-M mod 2^(K*N) is correct because T < 2M.
// - Back-to-back: start is accepted in the cycle done is high, or any later cycle.
// - rst_n low mid-operation: immediate return to reset state; partial data discarded, no done.
// - Throughput: N input cycles + N output cycles with no stalls, minimum 2N+1 cycles start-to-done.
// TESTING
// - All cases use K=8, N=2, M=0x0301 (m words 01,03).
// - T=0x0405, t_msb=0, words 05,04 -> res 04,01 (idx 0,1), then done 1 cycle.
// - T=0x0205 < M -> borrow out, sel=0 -> res 05,02 unchanged.
// - T=M=0x0301 -> res 00,00; t_msb=1, T words 00,00 -> res FF,FC (0x10000-0x301).
// - Stalls:
//   - in_valid toggled 1,0,1 yields the same result as the unstalled run.
//   - res_ready low 3 cycles on word 0: res_word/res_idx stay stable, no word skipped or duplicated.
// - start pulsed during SUB and OUT -> ignored, result unaffected.
//   start in the done cycle -> new operation accepted.
// - rst_n asserted during OUT -> res_valid=0, busy=0 asynchronously, no done.
//   Next start runs cleanly.

Source files
------------

// File: rtl/iddmm_final_sub.sv
// Final conditional subtraction of the IDDMM Montgomery multiplier: buffers T and T-M word
// by word, then streams R = (T >= M) ? T-M : T out LSW first under valid/ready.
module iddmm_final_sub #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              t_msb,
  input  logic              in_valid,
  input  logic [K-1:0]      t_word,
  input  logic [K-1:0]      m_word,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_word,
  output logic [ADDR_W-1:0] res_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_borrow;
  logic              r_sel;
  logic              r_t_msb;
  logic [K-1:0]      r_buf_t [N];
  logic [K-1:0]      r_buf_d [N];

  logic [K:0]        w_diff;
  logic              w_sel_next;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic [K-1:0]      w_first_t;
  logic [K-1:0]      w_first_d;

  // One word of the borrow chain; the top bit is the borrow into the next word.
  assign w_diff     = {1'b0, t_word} - {1'b0, m_word} - (K+1)'(r_borrow);
  assign w_sel_next = r_t_msb | ~w_diff[K];
  assign w_in_fire  = (r_state == S_SUB) && in_valid;
  assign w_out_fire = (r_state == S_OUT) && res_valid && res_ready;
  assign w_cnt_inc  = r_cnt + ADDR_W'(1);

  // Word 0 comes from the buffer unless it is the word arriving right now (N == 1).
  assign w_first_t  = (r_cnt == '0) ? t_word          : r_buf_t[0];
  assign w_first_d  = (r_cnt == '0) ? w_diff[K-1:0]   : r_buf_d[0];

  // NOTE: the operand buffers are plain storage with no reset; every entry is written
  // during SUB before OUT can read it, so a reset would only cost area and timing.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf_t[r_cnt] <= t_word;
      r_buf_d[r_cnt] <= w_diff[K-1:0];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees the
  // pre-edge values of r_cnt/r_borrow, matching the hardware registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_borrow  <= 1'b0;
      r_sel     <= 1'b0;
      r_t_msb   <= 1'b0;
      res_valid <= 1'b0;
      res_word  <= '0;
      res_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_t_msb  <= t_msb;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_SUB;
          end
        end

        S_SUB: begin
          if (in_valid) begin
            r_borrow <= w_diff[K];
            if (r_cnt == LAST_IDX) begin
              r_sel     <= w_sel_next;
              r_cnt     <= '0;
              res_valid <= 1'b1;
              res_idx   <= '0;
              res_word  <= w_sel_next ? w_first_d : w_first_t;
              r_state   <= S_OUT;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end

        S_OUT: begin
          if (w_out_fire) begin
            if (r_cnt == LAST_IDX) begin
              res_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_cnt    <= w_cnt_inc;
              res_idx  <= w_cnt_inc;
              res_word <= r_sel ? r_buf_d[w_cnt_inc] : r_buf_t[w_cnt_inc];
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iddmm_final_sub.sv
// Directed bench for iddmm_final_sub at K=8, N=2, M=0x0301; expected words computed by hand.
module tb_iddmm_final_sub;

  localparam int K = 8;
  localparam int N = 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         t_msb;
  logic         in_valid;
  logic [K-1:0] t_word;
  logic [K-1:0] m_word;
  logic         res_valid;
  logic         res_ready;
  logic [K-1:0] res_word;
  logic [0:0]   res_idx;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  iddmm_final_sub #(.K(K), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .t_msb     (t_msb),
    .in_valid  (in_valid),
    .t_word    (t_word),
    .m_word    (m_word),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_word  (res_word),
    .res_idx   (res_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start from the current negedge; ends one negedge later with busy expected high.
  task automatic do_start(input logic msb, input string tag);
    start = 1'b1;
    t_msb = msb;
    @(negedge clk);
    start = 1'b0;
    t_msb = 1'b0;
    check({tag, "_busy"}, busy, 1);
  endtask

  // Feeds T words against M = {03,01}; optional one-cycle in_valid gap and start poke.
  task automatic feed(input logic [7:0] t0, input logic [7:0] t1,
                      input logic stall, input logic poke_start);
    in_valid = 1'b1; t_word = t0; m_word = 8'h01; start = poke_start;
    @(negedge clk);
    if (stall) begin
      in_valid = 1'b0; t_word = 8'hAA; m_word = 8'h55;
      @(negedge clk);
    end
    in_valid = 1'b1; t_word = t1; m_word = 8'h03; start = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; t_word = 8'h00; m_word = 8'h00;
  endtask

  // Collects both result words; ends at the negedge where done should be high.
  task automatic drain(input logic [7:0] e0, input logic [7:0] e1, input int hold,
                       input logic poke_start, input string tag);
    check({tag, "_v0"}, res_valid, 1);
    check({tag, "_w0"}, res_word, e0);
    check({tag, "_i0"}, res_idx, 0);
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_w0"}, res_word, e0);
      check({tag, "_hold_i0"}, res_idx, 0);
      check({tag, "_hold_v"}, res_valid, 1);
    end
    res_ready = 1'b1;
    start = poke_start;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_v1"}, res_valid, 1);
    check({tag, "_w1"}, res_word, e1);
    check({tag, "_i1"}, res_idx, 1);
    check({tag, "_done_early"}, done, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_v_off"}, res_valid, 0);
  endtask

  task automatic idle_after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; t_msb = 1'b0; in_valid = 1'b0;
    t_word = '0; m_word = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_word",  res_word, 0);
    check("rst_idx",   res_idx, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid outside SUB must not start anything
    in_valid = 1'b1; t_word = 8'h77; m_word = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_inv_busy", busy, 0);
    check("idle_inv_valid", res_valid, 0);

    // T=0x0405 >= M: 0x0405-0x0301 = 0x0104
    do_start(1'b0, "basic");
    feed(8'h05, 8'h04, 1'b0, 1'b0);
    drain(8'h04, 8'h01, 0, 1'b0, "basic");
    idle_after_done("basic");

    // T=0x0205 < M: result unchanged
    do_start(1'b0, "lt");
    feed(8'h05, 8'h02, 1'b0, 1'b0);
    drain(8'h05, 8'h02, 0, 1'b0, "lt");
    idle_after_done("lt");

    // T == M: result zero
    do_start(1'b0, "eq");
    feed(8'h01, 8'h03, 1'b0, 1'b0);
    drain(8'h00, 8'h00, 0, 1'b0, "eq");
    idle_after_done("eq");

    // t_msb=1, low words 00,00: 0x10000-0x0301 = 0xFCFF
    do_start(1'b1, "msb");
    feed(8'h00, 8'h00, 1'b0, 1'b0);
    drain(8'hFF, 8'hFC, 0, 1'b0, "msb");
    idle_after_done("msb");

    // in_valid gap with garbage on the bus
    do_start(1'b0, "install");
    feed(8'h05, 8'h04, 1'b1, 1'b0);
    drain(8'h04, 8'h01, 0, 1'b0, "install");
    idle_after_done("install");

    // res_ready low for three cycles on word 0
    do_start(1'b0, "outstall");
    feed(8'h05, 8'h04, 1'b0, 1'b0);
    drain(8'h04, 8'h01, 3, 1'b0, "outstall");
    idle_after_done("outstall");

    // start poked during SUB and OUT, then restarted in the done cycle
    do_start(1'b0, "poke");
    feed(8'h05, 8'h02, 1'b0, 1'b1);
    drain(8'h05, 8'h02, 0, 1'b1, "poke");
    do_start(1'b0, "b2b");
    feed(8'h01, 8'h03, 1'b0, 1'b0);
    drain(8'h00, 8'h00, 0, 1'b0, "b2b");
    idle_after_done("b2b");

    // Asynchronous reset while results are pending
    do_start(1'b0, "rstout");
    feed(8'h05, 8'h04, 1'b0, 1'b0);
    check("rstout_pre_valid", res_valid, 1);
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstout_valid", res_valid, 0);
    check("rstout_busy", busy, 0);
    check("rstout_idx", res_idx, 0);
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstout_no_done", done, 0);
    end

    do_start(1'b1, "after_rst");
    feed(8'h00, 8'h00, 1'b0, 1'b0);
    drain(8'hFF, 8'hFC, 0, 1'b0, "after_rst");
    idle_after_done("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit reached");
  end

endmodule
